// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encoding, controller states and
// default multi-cycle latencies.
package mdu_pkg;

  // Operation codes driven on mdu.op by the E-stage decoder.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  // Controller state: idle (accepting) or running a multi-cycle op.
  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Default busy windows in cycles.
  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   op     - latched operation code (mdu_op_e encoding)
//   a, b   - latched rs/rt operands
//   result - {hi, lo} value to commit at the end of the busy window
//   wr     - 1 when result must be written; 0 for divide by zero or
//            for op codes that are not multiply/divide
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        wr
);

  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, div_b;
  logic [31:0] qs_mag, rs_mag, qs, rs;
  logic [31:0] qu, ru;
  logic        b_zero;

  assign a_sx = {{32{a[31]}}, a};
  assign b_sx = {{32{b[31]}}, b};
  assign a_zx = {32'd0, a};
  assign b_zx = {32'd0, b};

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  assign b_zero = (b == 32'd0);
  // Substitute a harmless divisor when b is zero; the result is discarded.
  assign div_b  = b_zero ? 32'd1 : b;

  // Signed divide on magnitudes. The magnitude of 0x80000000 is itself as an
  // unsigned value, so 0x80000000 / -1 yields quotient 0x80000000, rem 0.
  assign a_mag  = a[31] ? (32'd0 - a) : a;
  assign b_mag  = b_zero ? 32'd1 : (b[31] ? (32'd0 - b) : b);
  assign qs_mag = a_mag / b_mag;
  assign rs_mag = a_mag % b_mag;
  assign qs     = (a[31] ^ b[31]) ? (32'd0 - qs_mag) : qs_mag;
  assign rs     = a[31] ? (32'd0 - rs_mag) : rs_mag;

  assign qu = a / div_b;
  assign ru = a % div_b;

  always_comb begin
    result = 64'd0;
    wr     = 1'b0;
    case (op)
      MDU_MULT:  begin result = prod_s;    wr = 1'b1;    end
      MDU_MULTU: begin result = prod_u;    wr = 1'b1;    end
      MDU_DIV:   begin result = {rs, qs};  wr = !b_zero; end
      MDU_DIVU:  begin result = {ru, qu};  wr = !b_zero; end
      default:   begin result = 64'd0;     wr = 1'b0;    end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage. Owns HI/LO.
// Ports:
//   clk, reset     - clock (rising edge), asynchronous active-high reset
//   start, op      - MDU request from E; accepted only when busy is low
//   rs_val, rt_val - forwarded operands
//   hi, lo         - architectural HI/LO registers
//   busy           - multi-cycle op in flight (also the controller state)
// Handshake: a request is taken on a rising edge where start=1 and busy=0.
// MTHI/MTLO commit on that edge; MULT/DIV raise busy for exactly N cycles and
// commit HI/LO on the edge that drops busy. Requests while busy are dropped.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

  mdu_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [31:0]   hi_n, lo_n;
  logic          latch;
  logic [63:0]   arith_result;
  logic          arith_wr;

  mdu_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (arith_result),
    .wr     (arith_wr)
  );

  assign busy = (state == MDU_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MDU_IDLE;
      cnt   <= '0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      if (latch) begin
        op_q <= op;
        a_q  <= rs_val;
        b_q  <= rt_val;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    latch   = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              latch   = 1'b1;
              cnt_n   = MUL_N;
              state_n = MDU_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              latch   = 1'b1;
              cnt_n   = DIV_N;
              state_n = MDU_RUN;
            end
            MDU_MTHI: hi_n = rs_val;
            MDU_MTLO: lo_n = rs_val;
            default: ;  // undefined op codes are no-ops
          endcase
        end
      end
      MDU_RUN: begin
        // start is ignored here: the hazard unit never issues while busy.
        if (cnt <= CW'(1)) begin
          cnt_n   = '0;
          state_n = MDU_IDLE;
          if (arith_wr) begin
            hi_n = arith_result[63:32];
            lo_n = arith_result[31:0];
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = MDU_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized ops,
// checked against a longint arithmetic reference model.
module tb_mdu;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int checks;
  int failures;

  logic [31:0] m_hi, m_lo;
  logic [63:0] exp_q[$];

  mdu #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] ch,
                                               input logic [31:0] cl);
    longint sa, sb, q, r;
    longint unsigned ua, ub, up;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    res = {ch, cl};
    case (o)
      3'd0: res = 64'(sa * sb);
      3'd1: begin up = ua * ub; res = 64'(up); end
      3'd2: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd3: if (b != 0) begin
        up = ua / ub;
        res[31:0] = up[31:0];
        up = ua % ub;
        res[63:32] = up[31:0];
      end
      3'd4: res = {a, cl};
      3'd5: res = {ch, a};
      default: res = {ch, cl};
    endcase
    return res;
  endfunction

  function automatic int model_latency(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd1) return MUL_N;
    if (o == 3'd2 || o == 3'd3) return DIV_N;
    return 0;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    step();
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  // Issue one op, follow it to completion and check it. Returns at the
  // first sample point where busy is low, so a following op is back-to-back.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    int n, cycles, guard;
    bit stable;
    logic [63:0] exp;
    logic [31:0] old_hi, old_lo;
    n = model_latency(o);
    exp_q.push_back(model_result(o, a, b, m_hi, m_lo));
    old_hi = hi;
    old_lo = lo;
    drive_req(o, a, b);
    cycles = 0;
    guard  = 0;
    stable = 1'b1;
    while (busy === 1'b1 && guard < 100) begin
      cycles++;
      if (hi !== old_hi || lo !== old_lo) stable = 1'b0;
      step();
      guard++;
    end
    checks++;
    if (cycles != n) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cycles, n);
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL %s hilo_stable_while_busy: got changed expected held %h_%h", name, old_hi, old_lo);
    end
    exp = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== exp) begin
      failures++;
      $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b expected 0 0 0", hi, lo, busy);
    end
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    step();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got hi=%h lo=%h busy=%b expected 0 0 0", hi, lo, busy);
    end
    run_op("mthi", 3'd4, 32'h1234_5678, 32'h0);
    checks++;
    if (hi !== 32'h1234_5678) begin
      failures++;
      $display("FAIL mthi_value: got %h expected %h", hi, 32'h1234_5678);
    end
  endtask

  task automatic test_mult();
    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      failures++;
      $display("FAIL mult_const: got %h_%h expected ffffffff_fffffffa", hi, lo);
    end
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    checks++;
    if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      failures++;
      $display("FAIL multu_const: got %h_%h expected 00000002_fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL div_const: got %h_%h expected ffffffff_fffffffd", hi, lo);
    end
    run_op("divu", 3'd3, 32'd7, 32'd2);
    checks++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      failures++;
      $display("FAIL divu_const: got %h_%h expected 00000001_00000003", hi, lo);
    end
  endtask

  task automatic test_div_edge();
    run_op("preload_hi", 3'd4, 32'hAAAA_0000, 32'h0);
    run_op("preload_lo", 3'd5, 32'h0000_BBBB, 32'h0);
    run_op("div_by_zero", 3'd2, 32'd5, 32'd0);
    checks++;
    if (hi !== 32'hAAAA_0000 || lo !== 32'h0000_BBBB) begin
      failures++;
      $display("FAIL div_by_zero_hold: got %h_%h expected aaaa0000_0000bbbb", hi, lo);
    end
    run_op("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      failures++;
      $display("FAIL div_overflow_const: got %h_%h expected 00000000_80000000", hi, lo);
    end
  endtask

  task automatic test_reset_mid_op();
    bit bad;
    run_op("pre_hi", 3'd4, 32'h5555_1111, 32'h0);
    run_op("pre_lo", 3'd5, 32'h2222_6666, 32'h0);
    drive_req(3'd0, 32'h0000_1234, 32'h0000_5678);  // busy cycle 1
    step();                                          // busy cycle 2
    step();                                          // busy cycle 3
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_busy_before: got %b expected 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_async: got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
    #1 reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_mid_no_late_write: got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    logic [31:0] mult_hi, new_lo;
    int guard;
    exp = model_result(3'd0, 32'h0001_0003, 32'hFFFF_0007, m_hi, m_lo);
    drive_req(3'd0, 32'h0001_0003, 32'hFFFF_0007);
    // Requests while busy must be dropped.
    drive_req(3'd0, 32'h7777_7777, 32'h3333_3333);
    drive_req(3'd4, 32'hDEAD_BEEF, 32'h0);
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    checks++;
    if ({hi, lo} !== exp) begin
      failures++;
      $display("FAIL ignore_while_busy: got %h_%h expected %h_%h", hi, lo, exp[63:32], exp[31:0]);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    mult_hi = exp[63:32];
    new_lo = $urandom;
    // First cycle busy is low: issue MTLO immediately.
    drive_req(3'd5, new_lo, 32'h0);
    checks++;
    if (lo !== new_lo || hi !== mult_hi || busy !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_mtlo: got hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0",
               hi, lo, busy, mult_hi, new_lo);
    end
    m_lo = new_lo;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op("random", o, a, b);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 3'd0;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    #1;
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
